btn_debounce_ctrl: RTL

- Input-side counterpart to the LED pattern drivers.
- Conditions raw board push-buttons (C/U/D/L/R) into clean, debounced levels and single-cycle press/release events.
- LED/display controllers consume these events instead of raw pins.
- Sits between the top-level button pins and every control FSM, in the system clock domain.

---
 rtl/btn_debounce_ctrl_pkg.sv | 27 ++
 rtl/btn_debounce_ctrl_cell.sv | 164 ++++++++++++++++
 rtl/btn_debounce_ctrl.sv | 60 ++++++
 3 files changed

// File: rtl/btn_debounce_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_ctrl_pkg
// Description : Shared definitions for the push-button debounce controller.
//               - Per-button FSM state encoding.
//               - Board button index constants (bit i of the button bus).
// Revision    : 1.0 - initial release
// ============================================================================
package btn_debounce_ctrl_pkg;

  // Debounce FSM states; the encoding is fixed and shared with other blocks.
  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Board button positions on the btn_raw bus.
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;

endpackage : btn_debounce_ctrl_pkg
`default_nettype wire

// File: rtl/btn_debounce_ctrl_cell.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_cell
// Description : Debounces a single push-button.
//               2-FF synchronizer, 4-state debounce FSM with stability
//               counter, registered level and one-cycle press/release pulses.
//               Optional long-press detector when BTN_LONG_PRESS_EN is
//               defined; otherwise btn_long is tied to 0.
// Ports       : clk         - system clock
//               rst_n       - synchronous active-low reset
//               btn_raw     - asynchronous raw pin, 1 = pressed
//               btn_level   - debounced level (registered)
//               btn_press   - 1-cycle pulse on accepted press
//               btn_release - 1-cycle pulse on accepted release
//               btn_long    - 1-cycle pulse on long press
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_cell
  import btn_debounce_ctrl_pkg::*;
#(
  parameter int CNT_W        = 20,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_s1;
  logic             r_s;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;

  btn_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_level_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1      <= 1'b0;
      r_s       <= 1'b0;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_s1      <= btn_raw;
      r_s       <= r_s1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // The counter only runs in the two WAIT states and is cleared on every
  // state change, so it can never exceed DEBOUNCE_CYC-1 and never wraps.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_s) begin
          w_state_nxt = S_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!r_s) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = S_HELD;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (!r_s) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (r_s) begin
          w_state_nxt = S_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = '0;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

`ifdef BTN_LONG_PRESS_EN
  localparam int                LCNT_W      = $clog2(LONG_CYC + 1);
  localparam logic [LCNT_W-1:0] c_long_last = LCNT_W'(LONG_CYC - 1);
  localparam logic [LCNT_W-1:0] c_long_max  = LCNT_W'(LONG_CYC);

  logic [LCNT_W-1:0] r_lcnt;
  logic              r_long;

  // lcnt restarts only on a fresh accepted press; a bounce through
  // RELEASE_WAIT back to HELD keeps the hold time accumulated so far.
  // Saturating one past the trigger value guarantees a single pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lcnt <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (r_state == S_PRESS_WAIT && w_state_nxt == S_HELD) begin
        r_lcnt <= '0;
      end else if (r_state == S_HELD) begin
        if (r_lcnt == c_long_last) begin
          r_long <= 1'b1;
        end
        if (r_lcnt != c_long_max) begin
          r_lcnt <= r_lcnt + 1'b1;
        end
      end
    end
  end

  assign btn_long = r_long;
`else
  assign btn_long = 1'b0;
`endif

endmodule : btn_debounce_cell
`default_nettype wire

// File: rtl/btn_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_ctrl
// Description : Debounces N_BTN raw board push-buttons into clean levels and
//               single-cycle press/release (and optional long-press) events.
//               One btn_debounce_cell per button; buttons are independent.
//               Optional feature macro: BTN_LONG_PRESS_EN (long-press pulse
//               on btn_long; when undefined btn_long is constant 0).
// Ports       : clk         - system clock
//               rst_n       - synchronous active-low reset
//               btn_raw     - raw button pins, 1 = pressed
//               btn_level   - debounced levels
//               btn_press   - 1-cycle press pulses
//               btn_release - 1-cycle release pulses
//               btn_long    - 1-cycle long-press pulses
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_ctrl
  import btn_debounce_ctrl_pkg::*;
#(
  parameter int N_BTN        = 5,
  parameter int CNT_W        = 20,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 100000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  if (DEBOUNCE_CYC == 0 || longint'(DEBOUNCE_CYC) >= (longint'(1) << CNT_W)) begin : g_bad_debounce
    $error("btn_debounce_ctrl: DEBOUNCE_CYC must be in 1 .. 2^CNT_W-1");
  end

  if (LONG_CYC < 1) begin : g_bad_long
    $error("btn_debounce_ctrl: LONG_CYC must be at least 1");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce_cell #(
      .CNT_W        (CNT_W),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC)
    ) u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_long    (btn_long[i])
    );
  end

endmodule : btn_debounce_ctrl
`default_nettype wire
